// File: rtl/udp_header_parser.sv
// UDP header parser: captures the 8-byte header of each byte-serial packet and
// gates the following payload bytes to the forwarder, or drops them on a port mismatch.
module udp_header_parser (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  data_in,
    input  logic        data_valid_in,
    input  logic        sof_in,
    output logic        ready_out,
    input  logic [15:0] cfg_dst_port,
    input  logic        cfg_filter_en,
    input  logic        ready_in,
    output logic [7:0]  data_out,
    output logic        data_valid_out,
    output logic        header_done,
    output logic        fwd_enable,
    output logic        drop_enable,
    output logic [15:0] src_port,
    output logic [15:0] dst_port,
    output logic [15:0] udp_length,
    output logic [15:0] udp_checksum,
    output logic        pkt_done,
    output logic        hdr_error
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HEADER  = 2'd1,
        PAYLOAD = 2'd2,
        DROP    = 2'd3
    } state_t;

    state_t      state;
    logic [2:0]  hdr_cnt;
    logic [15:0] remaining;
    logic        accept;

    // Only PAYLOAD lets the forwarder throttle us; every other state always sinks bytes.
    always_comb begin
        ready_out = 1'b0;
        if (rst_n) begin
            ready_out = (state == PAYLOAD) ? ready_in : 1'b1;
        end
    end

    assign data_valid_out = (state == PAYLOAD) && data_valid_in;
    assign data_out       = (state == PAYLOAD) ? data_in : 8'h00;
    assign accept         = data_valid_in && ready_out;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            hdr_cnt      <= 3'd0;
            remaining    <= 16'd0;
            header_done  <= 1'b0;
            pkt_done     <= 1'b0;
            hdr_error    <= 1'b0;
            fwd_enable   <= 1'b0;
            drop_enable  <= 1'b0;
            src_port     <= 16'd0;
            dst_port     <= 16'd0;
            udp_length   <= 16'd0;
            udp_checksum <= 16'd0;
        end else begin
            header_done <= 1'b0;
            pkt_done    <= 1'b0;
            hdr_error   <= 1'b0;
            if (accept) begin
                if (sof_in) begin
                    // A start-of-frame outside IDLE aborts the packet in flight.
                    hdr_error      <= (state != IDLE);
                    src_port[15:8] <= data_in;
                    hdr_cnt        <= 3'd1;
                    state          <= HEADER;
                    fwd_enable     <= 1'b0;
                    drop_enable    <= 1'b0;
                end else begin
                    case (state)
                        IDLE: begin
                        end
                        HEADER: begin
                            hdr_cnt <= hdr_cnt + 3'd1;
                            case (hdr_cnt)
                                3'd1: src_port[7:0]       <= data_in;
                                3'd2: dst_port[15:8]      <= data_in;
                                3'd3: dst_port[7:0]       <= data_in;
                                3'd4: udp_length[15:8]    <= data_in;
                                3'd5: udp_length[7:0]     <= data_in;
                                3'd6: udp_checksum[15:8]  <= data_in;
                                3'd7: begin
                                    udp_checksum[7:0] <= data_in;
                                    if (udp_length < 16'd8) begin
                                        hdr_error <= 1'b1;
                                        state     <= IDLE;
                                    end else if (udp_length == 16'd8) begin
                                        header_done <= 1'b1;
                                        pkt_done    <= 1'b1;
                                        state       <= IDLE;
                                    end else begin
                                        header_done <= 1'b1;
                                        remaining   <= udp_length - 16'd8;
                                        if (cfg_filter_en && (dst_port != cfg_dst_port)) begin
                                            state       <= DROP;
                                            drop_enable <= 1'b1;
                                        end else begin
                                            state      <= PAYLOAD;
                                            fwd_enable <= 1'b1;
                                        end
                                    end
                                end
                                default: begin
                                end
                            endcase
                        end
                        PAYLOAD, DROP: begin
                            remaining <= remaining - 16'd1;
                            if (remaining == 16'd1) begin
                                pkt_done    <= 1'b1;
                                state       <= IDLE;
                                fwd_enable  <= 1'b0;
                                drop_enable <= 1'b0;
                            end
                        end
                        default: state <= IDLE;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_udp_header_parser.sv
// Self-checking bench for udp_header_parser: directed scenarios plus random packets,
// judged against a packet-level reference model built from the header bytes.
module tb_udp_header_parser;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  data_in;
    logic        data_valid_in;
    logic        sof_in;
    logic        ready_out;
    logic [15:0] cfg_dst_port;
    logic        cfg_filter_en;
    logic        ready_in;
    logic [7:0]  data_out;
    logic        data_valid_out;
    logic        header_done;
    logic        fwd_enable;
    logic        drop_enable;
    logic [15:0] src_port;
    logic [15:0] dst_port;
    logic [15:0] udp_length;
    logic [15:0] udp_checksum;
    logic        pkt_done;
    logic        hdr_error;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    int n_hd = 0, n_pd = 0, n_err = 0, n_fwd_cyc = 0, n_drop_cyc = 0;
    int n_dv_drop = 0, n_rdy_bad = 0, n_both = 0;
    int hd_cyc = 0, pd_cyc = 0, err_cyc = 0, sof_cyc = 0;
    logic [7:0] fwd_q[$];
    logic [7:0] pkt[$];
    logic [7:0] prev_pkt[$];
    logic [7:0] exp_q[$];
    int s_hd, s_pd, s_err, s_fwd_cyc, s_drop_cyc, s_dv_drop, s_rdy_bad, s_both, s_q;
    int byte7_cyc = 0;
    int last_cyc = 0;
    bit toggle_mode = 1'b0;

    udp_header_parser dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .data_in        (data_in),
        .data_valid_in  (data_valid_in),
        .sof_in         (sof_in),
        .ready_out      (ready_out),
        .cfg_dst_port   (cfg_dst_port),
        .cfg_filter_en  (cfg_filter_en),
        .ready_in       (ready_in),
        .data_out       (data_out),
        .data_valid_out (data_valid_out),
        .header_done    (header_done),
        .fwd_enable     (fwd_enable),
        .drop_enable    (drop_enable),
        .src_port       (src_port),
        .dst_port       (dst_port),
        .udp_length     (udp_length),
        .udp_checksum   (udp_checksum),
        .pkt_done       (pkt_done),
        .hdr_error      (hdr_error)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Passive observer: tallies pulses, the forwarded byte stream and handshake sanity.
    always @(negedge clk) begin
        if (rst_n) begin
            if (header_done) begin n_hd++; hd_cyc = cyc; end
            if (pkt_done) begin n_pd++; pd_cyc = cyc; end
            if (hdr_error) begin n_err++; err_cyc = cyc; end
            if (data_valid_in && ready_out && sof_in) sof_cyc = cyc;
            if (data_valid_out && ready_out) fwd_q.push_back(data_out);
            if (fwd_enable) n_fwd_cyc++;
            if (drop_enable) n_drop_cyc++;
            if (drop_enable && data_valid_out) n_dv_drop++;
            if (fwd_enable && (ready_out !== ready_in)) n_rdy_bad++;
            if (fwd_enable && drop_enable) n_both++;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idleCycles(input int n);
        data_valid_in = 1'b0;
        sof_in        = 1'b0;
        repeat (n) begin
            data_in = 8'($urandom);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic applyStimulus(input logic [7:0] b, input logic sof);
        bit done = 1'b0;
        int tries = 0;
        data_in       = b;
        sof_in        = sof;
        data_valid_in = 1'b1;
        while (!done && tries < 64) begin
            tries++;
            @(negedge clk);
            done = (ready_out === 1'b1);
            @(posedge clk);
            #1;
            if (toggle_mode) ready_in = ~ready_in;
            else ready_in = 1'b1;
        end
        if (!done) begin
            checks++;
            errors++;
            $error("[TB] FAIL accept_timeout: observed no acceptance, expected byte 0x%0h accepted", b);
        end
        last_cyc      = cyc;
        data_valid_in = 1'b0;
        sof_in        = 1'b0;
    endtask

    task automatic buildPacket(input logic [15:0] sp, input logic [15:0] dp,
                               input logic [15:0] len, input logic [15:0] ck);
        pkt.delete();
        pkt.push_back(sp[15:8]); pkt.push_back(sp[7:0]);
        pkt.push_back(dp[15:8]); pkt.push_back(dp[7:0]);
        pkt.push_back(len[15:8]); pkt.push_back(len[7:0]);
        pkt.push_back(ck[15:8]); pkt.push_back(ck[7:0]);
        for (int i = 8; i < int'(len); i++) pkt.push_back(8'($urandom));
    endtask

    task automatic sendPacket(input int stall_max, input int upto);
        for (int i = 0; i < upto; i++) begin
            applyStimulus(pkt[i], (i == 0));
            if (i == 7) byte7_cyc = last_cyc;
            if (stall_max > 0 && i + 1 < upto) idleCycles(int'($urandom_range(stall_max)));
        end
    endtask

    task automatic takeSnapshot();
        s_hd = n_hd; s_pd = n_pd; s_err = n_err; s_fwd_cyc = n_fwd_cyc;
        s_drop_cyc = n_drop_cyc; s_dv_drop = n_dv_drop; s_rdy_bad = n_rdy_bad;
        s_both = n_both; s_q = fwd_q.size();
    endtask

    task automatic checkFields(input string tag);
        checkOutput({tag, "/src_port"}, 32'(src_port), 32'({pkt[0], pkt[1]}));
        checkOutput({tag, "/dst_port"}, 32'(dst_port), 32'({pkt[2], pkt[3]}));
        checkOutput({tag, "/udp_length"}, 32'(udp_length), 32'({pkt[4], pkt[5]}));
        checkOutput({tag, "/udp_checksum"}, 32'(udp_checksum), 32'({pkt[6], pkt[7]}));
    endtask

    // Packet-level reference: what a complete packet should produce, from its header alone.
    task automatic checkPacket(input string tag, input bit filt, input logic [15:0] cfg, input bit exact);
        logic [15:0] dp, len;
        bit fwd;
        int beats;
        idleCycles(3);
        dp    = {pkt[2], pkt[3]};
        len   = {pkt[4], pkt[5]};
        beats = (len > 16'd8) ? int'(len) - 8 : 0;
        fwd   = !(filt && (dp != cfg));
        exp_q.delete();
        if (fwd) for (int i = 0; i < beats; i++) exp_q.push_back(pkt[8 + i]);
        checkFields(tag);
        checkOutput({tag, "/header_done_count"}, 32'(n_hd - s_hd), (len >= 16'd8) ? 32'd1 : 32'd0);
        checkOutput({tag, "/pkt_done_count"}, 32'(n_pd - s_pd), (len >= 16'd8) ? 32'd1 : 32'd0);
        checkOutput({tag, "/hdr_error_count"}, 32'(n_err - s_err), (len < 16'd8) ? 32'd1 : 32'd0);
        checkOutput({tag, "/fwd_byte_count"}, 32'(fwd_q.size() - s_q), 32'(exp_q.size()));
        if (fwd_q.size() - s_q == exp_q.size())
            for (int i = 0; i < exp_q.size(); i++)
                checkOutput({tag, "/fwd_byte"}, 32'(fwd_q[s_q + i]), 32'(exp_q[i]));
        if (len >= 16'd8) begin
            checkOutput({tag, "/header_done_cycle"}, 32'(hd_cyc), 32'(byte7_cyc));
            checkOutput({tag, "/pkt_done_cycle"}, 32'(pd_cyc), 32'(last_cyc));
        end else begin
            checkOutput({tag, "/hdr_error_cycle"}, 32'(err_cyc), 32'(byte7_cyc));
        end
        checkOutput({tag, "/valid_while_drop"}, 32'(n_dv_drop - s_dv_drop), 32'd0);
        checkOutput({tag, "/ready_mirror"}, 32'(n_rdy_bad - s_rdy_bad), 32'd0);
        checkOutput({tag, "/fwd_and_drop"}, 32'(n_both - s_both), 32'd0);
        checkOutput({tag, "/fwd_enable_after"}, 32'(fwd_enable), 32'd0);
        checkOutput({tag, "/drop_enable_after"}, 32'(drop_enable), 32'd0);
        if (exact) begin
            checkOutput({tag, "/fwd_cycles"}, 32'(n_fwd_cyc - s_fwd_cyc), fwd ? 32'(beats) : 32'd0);
            checkOutput({tag, "/drop_cycles"}, 32'(n_drop_cyc - s_drop_cyc), fwd ? 32'd0 : 32'(beats));
        end
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "/ready_out"}, 32'(ready_out), 32'd0);
        checkOutput({tag, "/data_valid_out"}, 32'(data_valid_out), 32'd0);
        checkOutput({tag, "/data_out"}, 32'(data_out), 32'd0);
        checkOutput({tag, "/header_done"}, 32'(header_done), 32'd0);
        checkOutput({tag, "/pkt_done"}, 32'(pkt_done), 32'd0);
        checkOutput({tag, "/hdr_error"}, 32'(hdr_error), 32'd0);
        checkOutput({tag, "/fwd_enable"}, 32'(fwd_enable), 32'd0);
        checkOutput({tag, "/drop_enable"}, 32'(drop_enable), 32'd0);
        checkOutput({tag, "/fields"}, {src_port | dst_port, udp_length | udp_checksum}, 32'd0);
    endtask

    initial begin
        logic [15:0] r_dp, r_len, r_cfg;
        bit r_filt;

        rst_n         = 1'b0;
        data_in       = 8'hA5;
        data_valid_in = 1'b1;
        sof_in        = 1'b1;
        ready_in      = 1'b1;
        cfg_dst_port  = 16'h0000;
        cfg_filter_en = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkResetOutputs("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idleCycles(2);

        // Reference packet forwarded with filtering off.
        buildPacket(16'h1388, 16'h1388, 16'h000C, 16'hABCD);
        takeSnapshot();
        sendPacket(0, pkt.size());
        checkPacket("pass", 1'b0, 16'h0000, 1'b1);
        checkOutput("pass/len_const", 32'(udp_length), 32'h000C);

        // Same packet, destination port mismatch with filtering on.
        cfg_filter_en = 1'b1;
        cfg_dst_port  = 16'h1389;
        buildPacket(16'h1388, 16'h1388, 16'h000C, 16'hABCD);
        takeSnapshot();
        sendPacket(0, pkt.size());
        checkPacket("drop", 1'b1, 16'h1389, 1'b1);
        cfg_filter_en = 1'b0;

        // Header-only packet, then a normal packet.
        buildPacket(16'h0101, 16'h0202, 16'h0008, 16'h0303);
        takeSnapshot();
        sendPacket(0, pkt.size());
        checkPacket("len8", 1'b0, 16'h0000, 1'b1);
        buildPacket(16'h0A0B, 16'h0C0D, 16'h000B, 16'h0E0F);
        takeSnapshot();
        sendPacket(0, pkt.size());
        checkPacket("after_len8", 1'b0, 16'h0000, 1'b1);

        // Malformed length, then a well-formed packet.
        buildPacket(16'h1111, 16'h2222, 16'h0005, 16'h3333);
        takeSnapshot();
        sendPacket(0, pkt.size());
        checkPacket("short", 1'b0, 16'h0000, 1'b1);
        buildPacket(16'h4444, 16'h5555, 16'h000A, 16'h6666);
        takeSnapshot();
        sendPacket(0, pkt.size());
        checkPacket("after_short", 1'b0, 16'h0000, 1'b1);

        // Back-to-back packets: second sof arrives right after the last payload byte.
        buildPacket(16'h7001, 16'h7002, 16'h000A, 16'h7003);
        takeSnapshot();
        sendPacket(0, pkt.size());
        buildPacket(16'h8001, 16'h8002, 16'h0009, 16'h8003);
        sendPacket(0, pkt.size());
        idleCycles(3);
        checkFields("b2b");
        checkOutput("b2b/header_done_count", 32'(n_hd - s_hd), 32'd2);
        checkOutput("b2b/pkt_done_count", 32'(n_pd - s_pd), 32'd2);
        checkOutput("b2b/pkt_done_cycle", 32'(pd_cyc), 32'(last_cyc));
        checkOutput("b2b/last_fwd_byte", 32'(fwd_q[fwd_q.size() - 1]), 32'(pkt[8]));

        // Forwarder backpressure on every other cycle.
        toggle_mode = 1'b1;
        buildPacket(16'h9001, 16'h9002, 16'h0010, 16'h9003);
        takeSnapshot();
        sendPacket(0, pkt.size());
        toggle_mode = 1'b0;
        ready_in    = 1'b1;
        checkPacket("backpressure", 1'b0, 16'h0000, 1'b0);

        // Reset in the middle of a payload.
        buildPacket(16'hA001, 16'hA002, 16'h0014, 16'hA003);
        sendPacket(0, 11);
        data_in       = 8'h5A;
        data_valid_in = 1'b1;
        rst_n         = 1'b0;
        @(negedge clk);
        checkResetOutputs("mid_reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idleCycles(2);
        buildPacket(16'hB001, 16'hB002, 16'h000D, 16'hB003);
        takeSnapshot();
        sendPacket(0, pkt.size());
        checkPacket("after_reset", 1'b0, 16'h0000, 1'b1);

        // New sof at payload byte 2 aborts the packet in flight.
        buildPacket(16'hC001, 16'hC002, 16'h000C, 16'hC003);
        takeSnapshot();
        sendPacket(0, 10);
        prev_pkt = pkt;
        buildPacket(16'hD001, 16'hD002, 16'h000E, 16'hD003);
        sendPacket(0, pkt.size());
        idleCycles(3);
        checkFields("abort");
        checkOutput("abort/hdr_error_count", 32'(n_err - s_err), 32'd1);
        checkOutput("abort/hdr_error_cycle", 32'(err_cyc), 32'(sof_cyc + 1));
        checkOutput("abort/header_done_count", 32'(n_hd - s_hd), 32'd2);
        checkOutput("abort/pkt_done_count", 32'(n_pd - s_pd), 32'd1);
        checkOutput("abort/pkt_done_cycle", 32'(pd_cyc), 32'(last_cyc));
        checkOutput("abort/first_fwd_byte", 32'(fwd_q[s_q]), 32'(prev_pkt[8]));
        for (int i = 0; i < 6; i++)
            checkOutput("abort/tail_byte", 32'(fwd_q[fwd_q.size() - 6 + i]), 32'(pkt[8 + i]));

        // Random packets with random stalls, lengths, filtering and backpressure.
        for (int n = 0; n < 12; n++) begin
            r_dp   = 16'($urandom);
            r_len  = ($urandom_range(4) == 0) ? 16'($urandom_range(7)) : 16'(8 + $urandom_range(16));
            r_filt = 1'($urandom_range(1));
            r_cfg  = ($urandom_range(1) == 0) ? r_dp : (r_dp ^ 16'(1 + $urandom_range(200)));
            cfg_filter_en = r_filt;
            cfg_dst_port  = r_cfg;
            toggle_mode   = 1'($urandom_range(1));
            buildPacket(16'($urandom), r_dp, r_len, 16'($urandom));
            takeSnapshot();
            sendPacket(2, pkt.size());
            toggle_mode = 1'b0;
            ready_in    = 1'b1;
            checkPacket("random", r_filt, r_cfg, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/udp_header_parser.md
# udp_header_parser

Parses the 8-byte UDP header at the front of each byte-serial packet and captures source port, destination port, length and checksum. It then gates the payload bytes to the payload forwarder stage directly downstream. It produces the `header_done`, `fwd_enable` and `drop_enable` controls and the `udp_length` value that the forwarder consumes. Packets whose destination port does not match the configured port are consumed and dropped.

## Interface
- No parameters.
- `clk` in 1: single clock domain.
- `rst_n` in 1: reset, asynchronous, active-low.
- `data_in` in 8: upstream byte stream, starting at UDP header byte 0.
- `data_valid_in` in 1: `data_in` is valid.
- `sof_in` in 1: qualifies the current valid byte as the first byte of a packet.
- `ready_out` out 1: parser accepts a byte this cycle. A byte is accepted when `data_valid_in && ready_out`.
- `cfg_dst_port` in 16: destination port to forward.
- `cfg_filter_en` in 1: enables port filtering. When 0, all well-formed packets are forwarded.
- `ready_in` in 1: downstream (forwarder) ready.
- `data_out` out 8: payload byte to the forwarder.
- `data_valid_out` out 1: payload byte valid to the forwarder.
- `header_done` out 1: one-cycle pulse; header fields are valid and stable.
- `fwd_enable` out 1: high throughout payload forwarding.
- `drop_enable` out 1: high throughout payload dropping.
- `src_port`, `dst_port`, `udp_length`, `udp_checksum` out 16 each: captured header fields. They hold until the next header overwrites them.
- `pkt_done` out 1: one-cycle pulse after the last payload byte is accepted.
- `hdr_error` out 1: one-cycle pulse on a malformed or aborted packet.

## Operation
- FSM states: IDLE, HEADER, PAYLOAD, DROP. Internal counters: `hdr_cnt` (3-bit) and `remaining` (16-bit).
- **IDLE**
  - `ready_out`=1.
  - An accepted byte without `sof_in` is discarded.
  - An accepted byte with `sof_in` is stored as byte 0; `hdr_cnt` becomes 1 and the FSM moves to HEADER.
- **HEADER**
  - `ready_out`=1.
  - Bytes are captured big-endian: bytes 0-1 → `src_port`, 2-3 → `dst_port`, 4-5 → `udp_length`, 6-7 → `udp_checksum`.
  - When byte 7 is accepted, the next state is decided from the assembled length L:
    - L<8: `hdr_error` pulse, go to IDLE, no `header_done`.
    - L==8: `header_done` pulse and `pkt_done` pulse, go to IDLE.
    - `cfg_filter_en` high and `dst_port` != `cfg_dst_port`: `header_done` pulse, go to DROP, `remaining`=L-8.
    - Otherwise: `header_done` pulse, go to PAYLOAD, `remaining`=L-8.
  - The L-8 subtraction only occurs when L≥8, so it never underflows.
- **PAYLOAD**
  - `fwd_enable`=1.
  - `data_out`=`data_in`, `data_valid_out`=`data_valid_in`, `ready_out`=`ready_in`; all three are combinational pass-through.
  - Each accepted byte decrements `remaining`.
  - When the byte with `remaining`==1 is accepted, `pkt_done` pulses and the FSM goes to IDLE.
- **DROP**
  - `drop_enable`=1, `ready_out`=1, `data_valid_out`=0.
  - Bytes are consumed and `remaining` is decremented as in PAYLOAD, with the same `pkt_done` and transition to IDLE.
- **Abort:** `sof_in` on an accepted byte in HEADER (`hdr_cnt`≠0), PAYLOAD or DROP causes:
  - a `hdr_error` pulse;
  - the byte is taken as byte 0 of the new header;
  - `hdr_cnt`=1 and the state becomes HEADER.
- `cfg_dst_port` and `cfg_filter_en` are sampled only on the cycle byte 7 is accepted.

## Timing
- **Reset:** asserting `rst_n` low immediately and asynchronously forces:
  - state=IDLE;
  - all registered outputs and fields to 0: `header_done`, `pkt_done`, `hdr_error`, `fwd_enable`, `drop_enable`, all 16-bit fields;
  - `ready_out`=0 and `data_valid_out`=0 while `rst_n` is low.
  - Reset mid-packet discards the packet; the first packet after release needs `sof_in`.
- `header_done`, `pkt_done` and `hdr_error` are registered: they assert the cycle after the triggering byte is accepted, for exactly 1 cycle.
- `fwd_enable`/`drop_enable` are registered state decodes. They rise in the same cycle as `header_done` and fall in the same cycle as `pkt_done`.
- Header fields update on byte acceptance and are stable by the cycle `header_done` is high.
- Payload path latency is 0 cycles (combinational).
- Upstream stalls (`data_valid_in`=0) in any state hold the state and counters.
- Downstream backpressure (`ready_in`=0) in PAYLOAD deasserts `ready_out` with no byte lost.
- Back-to-back packets: the `sof_in` byte may arrive in the cycle immediately after the last payload byte and is accepted in IDLE.

## Test plan
- Header `13 88 13 88 00 0C AB CD` followed by 4 payload bytes, filter off, `ready_in`=1:
  - fields read 0x1388/0x1388/0x000C/0xABCD;
  - one `header_done` pulse;
  - `fwd_enable` high for exactly the 4 payload beats;
  - `data_out` equals the inputs;
  - `pkt_done` pulses once the cycle after byte 4.
- Same packet with `cfg_filter_en`=1, `cfg_dst_port`=0x1389:
  - `drop_enable` high for the 4 payload beats;
  - `data_valid_out` stays 0;
  - `pkt_done` pulses; `fwd_enable` never rises.
- `udp_length`=0x0008: `header_done` and `pkt_done` both pulse the cycle after byte 7; the FSM returns to IDLE; the next `sof_in` packet parses normally.
- `udp_length`=0x0005: `hdr_error` pulses; there is no `header_done`; the following well-formed packet parses correctly.
- PAYLOAD with `udp_length`=0x0010 and `ready_in` toggled every other cycle:
  - all 8 payload bytes are delivered in order;
  - `ready_out` mirrors `ready_in`;
  - no byte is duplicated or dropped.
- Reset asserted mid-payload, then `sof_in` asserted on a new packet 2 cycles after release: all outputs read 0 during reset, and the new header parses correctly.
- `sof_in` at payload byte 2: `hdr_error` pulses and the new packet's fields are captured correctly.
